// File: rtl/vga_pkg.sv
// Shared VGA timing package: coordinate types and default visible area.
package vga_pkg;
  localparam int X_W          = 12;
  localparam int Y_W          = 12;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef logic [X_W-1:0] x_coord_t;
  typedef logic [Y_W-1:0] y_coord_t;
endpackage

// File: rtl/scaled_axis_counter.sv
// One coordinate axis: raw count, replication sub-counter, scaled count.
module scaled_axis_counter #(
  parameter int W     = 12,
  parameter int SCALE = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         step_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] scnt_o,
  output logic [W-1:0] cnt_nxt_o
);
  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SW-1:0] SUB_MAX = SW'(SCALE - 1);

  logic [W-1:0]  r_cnt, r_scnt;
  logic [SW-1:0] r_sub;
  logic [W-1:0]  w_cnt_nxt, w_scnt_nxt;
  logic [SW-1:0] w_sub_nxt;

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_scnt_nxt = r_scnt;
    w_sub_nxt  = r_sub;
    if (clr_i) begin
      w_cnt_nxt  = '0;
      w_scnt_nxt = '0;
      w_sub_nxt  = '0;
    end else if (step_i) begin
      if (r_cnt == '1) begin
        // raw overflow realigns the scaled path to zero
        w_cnt_nxt  = '0;
        w_scnt_nxt = '0;
        w_sub_nxt  = '0;
      end else begin
        w_cnt_nxt = r_cnt + W'(1);
        if (r_sub == SUB_MAX) begin
          w_sub_nxt  = '0;
          w_scnt_nxt = r_scnt + W'(1);
        end else begin
          w_sub_nxt = r_sub + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_scnt <= '0;
      r_sub  <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_scnt <= w_scnt_nxt;
      r_sub  <= w_sub_nxt;
    end
  end

  assign cnt_o     = r_cnt;
  assign scnt_o    = r_scnt;
  assign cnt_nxt_o = w_cnt_nxt;
endmodule

// File: rtl/pixel_coord_scaler.sv
// Raw and scaled pixel coordinates with active/start-of-frame flags.
module pixel_coord_scaler
  import vga_pkg::*;
#(
  parameter int X_WIDTH     = $bits(x_coord_t),
  parameter int Y_WIDTH     = $bits(y_coord_t),
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SCALE_X     = 1,
  parameter int SCALE_Y     = 1,
  parameter int FRAME_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   eol_i,
  input  logic                   eof_i,
  output logic [X_WIDTH-1:0]     x_o,
  output logic [Y_WIDTH-1:0]     y_o,
  output logic [X_WIDTH-1:0]     sx_o,
  output logic [Y_WIDTH-1:0]     sy_o,
  output logic                   active_o,
  output logic                   sof_o,
  output logic [FRAME_WIDTH-1:0] frame_o
);
  if (SCALE_X < 1) begin : g_bad_sx
    $error("SCALE_X must be >= 1");
  end
  if (SCALE_Y < 1) begin : g_bad_sy
    $error("SCALE_Y must be >= 1");
  end
  if (64'(H_ACTIVE) > (64'd1 << X_WIDTH)) begin : g_bad_h
    $error("H_ACTIVE exceeds X range");
  end
  if (64'(V_ACTIVE) > (64'd1 << Y_WIDTH)) begin : g_bad_v
    $error("V_ACTIVE exceeds Y range");
  end

  localparam logic [X_WIDTH:0] H_LIM = (X_WIDTH + 1)'(H_ACTIVE);
  localparam logic [Y_WIDTH:0] V_LIM = (Y_WIDTH + 1)'(V_ACTIVE);

  logic                   w_x_clr, w_x_step, w_y_clr, w_y_step;
  logic [X_WIDTH-1:0]     w_x_nxt;
  logic [Y_WIDTH-1:0]     w_y_nxt;
  logic                   r_active, r_sof;
  logic [FRAME_WIDTH-1:0] r_frame;

  assign w_x_clr  = enable_i & eol_i;
  assign w_x_step = enable_i & ~eol_i;
  assign w_y_clr  = enable_i & eof_i;
  assign w_y_step = enable_i & eol_i & ~eof_i;

  scaled_axis_counter #(
    .W     (X_WIDTH),
    .SCALE (SCALE_X)
  ) u_x_axis (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (w_x_clr),
    .step_i    (w_x_step),
    .cnt_o     (x_o),
    .scnt_o    (sx_o),
    .cnt_nxt_o (w_x_nxt)
  );

  scaled_axis_counter #(
    .W     (Y_WIDTH),
    .SCALE (SCALE_Y)
  ) u_y_axis (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (w_y_clr),
    .step_i    (w_y_step),
    .cnt_o     (y_o),
    .scnt_o    (sy_o),
    .cnt_nxt_o (w_y_nxt)
  );

  // flags track the next coordinates so they line up with x_o/y_o
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_active <= 1'b1;
      r_sof    <= 1'b1;
      r_frame  <= '0;
    end else begin
      r_active <= ({1'b0, w_x_nxt} < H_LIM) &&
                  ({1'b0, w_y_nxt} < V_LIM);
      r_sof    <= (w_x_nxt == '0) && (w_y_nxt == '0);
      if (enable_i && eof_i) begin
        r_frame <= r_frame + FRAME_WIDTH'(1);
      end
    end
  end

  assign active_o = r_active;
  assign sof_o    = r_sof;
  assign frame_o  = r_frame;
endmodule

// File: tb/tb_pixel_coord_scaler.sv
// Directed bench for pixel_coord_scaler with SCALE_X=2, SCALE_Y=3.
module tb_pixel_coord_scaler;
  localparam int XW = 12;
  localparam int YW = 12;
  localparam int FW = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          enable_i, eol_i, eof_i;
  logic [XW-1:0] x_o, sx_o;
  logic [YW-1:0] y_o, sy_o;
  logic          active_o, sof_o;
  logic [FW-1:0] frame_o;

  int n_checks = 0;
  int n_errors = 0;

  pixel_coord_scaler #(
    .X_WIDTH     (XW),
    .Y_WIDTH     (YW),
    .H_ACTIVE    (640),
    .V_ACTIVE    (480),
    .SCALE_X     (2),
    .SCALE_Y     (3),
    .FRAME_WIDTH (FW)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (enable_i),
    .eol_i    (eol_i),
    .eof_i    (eof_i),
    .x_o      (x_o),
    .y_o      (y_o),
    .sx_o     (sx_o),
    .sy_o     (sy_o),
    .active_o (active_o),
    .sof_o    (sof_o),
    .frame_o  (frame_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic eol, input logic eof);
    enable_i = en;
    eol_i    = eol;
    eof_i    = eof;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_home(input string tag, input int fr);
    check({tag, ".x"}, 32'(x_o), 0);
    check({tag, ".y"}, 32'(y_o), 0);
    check({tag, ".sx"}, 32'(sx_o), 0);
    check({tag, ".sy"}, 32'(sy_o), 0);
    check({tag, ".active"}, 32'(active_o), 1);
    check({tag, ".sof"}, 32'(sof_o), 1);
    check({tag, ".frame"}, 32'(frame_o), 32'(fr));
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  int sy_tab [7] = '{0, 0, 0, 1, 1, 1, 2};

  initial begin
    rst_ni   = 1'b0;
    enable_i = 1'b0;
    eol_i    = 1'b0;
    eof_i    = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_home("reset", 0);
    rst_ni = 1'b1;

    for (int k = 0; k < 8; k++) begin
      check("run.x", 32'(x_o), 32'(k));
      check("run.sx", 32'(sx_o), 32'(k / 2));
      check("run.sof", 32'(sof_o), (k == 0) ? 1 : 0);
      if (k < 7) cyc(1, 0, 0);
    end

    for (int x = 8; x <= 799; x++) begin
      cyc(1, 0, 0);
      if (x == 639) check("line.active639", 32'(active_o), 1);
      if (x == 640) check("line.active640", 32'(active_o), 0);
    end
    check("line.x799", 32'(x_o), 799);
    check("line.sx799", 32'(sx_o), 399);
    cyc(1, 1, 0);
    check("eol.x", 32'(x_o), 0);
    check("eol.y", 32'(y_o), 1);
    check("eol.sx", 32'(sx_o), 0);
    check("eol.active", 32'(active_o), 1);

    pulse_reset();
    for (int y = 0; y < 7; y++) begin
      check("vscale.y", 32'(y_o), 32'(y));
      check("vscale.sy", 32'(sy_o), 32'(sy_tab[y]));
      if (y < 6) cyc(1, 1, 0);
    end
    check("vscale.x", 32'(x_o), 0);

    for (int y = 7; y <= 524; y++) cyc(1, 1, 0);
    check("frm.y524", 32'(y_o), 524);
    check("frm.sy524", 32'(sy_o), 174);
    repeat (799) cyc(1, 0, 0);
    check("frm.x799", 32'(x_o), 799);
    check("frm.active", 32'(active_o), 0);
    check("frm.frame0", 32'(frame_o), 0);
    cyc(1, 1, 1);
    check_home("eol_eof", 1);

    repeat (3) cyc(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1);
      check("hold.x", 32'(x_o), 3);
      check("hold.sx", 32'(sx_o), 1);
      check("hold.y", 32'(y_o), 0);
      check("hold.frame", 32'(frame_o), 1);
    end
    cyc(1, 0, 0);
    check("resume.x", 32'(x_o), 4);
    check("resume.sx", 32'(sx_o), 2);

    cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    check("eofonly.x", 32'(x_o), 2);
    check("eofonly.sx", 32'(sx_o), 1);
    check("eofonly.y", 32'(y_o), 0);
    check("eofonly.frame", 32'(frame_o), 2);
    check("eofonly.sof", 32'(sof_o), 0);

    repeat (5) cyc(1, 1, 1);
    repeat (200) cyc(1, 1, 0);
    repeat (300) cyc(1, 0, 0);
    check("pre.x", 32'(x_o), 300);
    check("pre.y", 32'(y_o), 200);
    check("pre.sx", 32'(sx_o), 150);
    check("pre.sy", 32'(sy_o), 66);
    check("pre.frame", 32'(frame_o), 7);
    check("pre.sof", 32'(sof_o), 0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_home("async_rst", 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check_home("rst_rel", 0);
    cyc(1, 0, 0);
    check("post.x1", 32'(x_o), 1);
    check("post.sx1", 32'(sx_o), 0);
    cyc(1, 0, 0);
    check("post.sx2", 32'(sx_o), 1);

    repeat (4093) cyc(1, 0, 0);
    check("ovf.x", 32'(x_o), 4095);
    check("ovf.sx", 32'(sx_o), 2047);
    check("ovf.active", 32'(active_o), 0);
    cyc(1, 0, 0);
    check("wrap.x", 32'(x_o), 0);
    check("wrap.sx", 32'(sx_o), 0);
    check("wrap.sof", 32'(sof_o), 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("wrap.x2", 32'(x_o), 2);
    check("wrap.sx2", 32'(sx_o), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
